// File: rtl/bcd_seg_pkg.sv
// bcd_seg_pkg
// Shared definitions for the multiplexed three-digit seven-segment driver.
//   - Active-high segment patterns {g,f,e,d,c,b,a} for 0-9, dash and blank
//   - Slot state enum for the digit scanner (DIG0 = ones, DIG1 = tens,
//     DIG2 = hundreds)
//   - bcd_digit(): extracts one digit from a packed 12-bit BCD value
package bcd_seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_NONE = 7'h00;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2
  } slot_t;

  // Digit idx of a packed {hundreds, tens, ones} value; idx 3 is unused.
  function automatic logic [3:0] bcd_digit(input logic [11:0] bcd,
                                           input logic [1:0]  idx);
    logic [3:0] d;
    case (idx)
      2'd0:    d = bcd[3:0];
      2'd1:    d = bcd[7:4];
      2'd2:    d = bcd[11:8];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_seg_scan_bcd_to_seg.sv
// bcd_to_seg
// Combinational 4-bit BCD to 7-segment decoder, active-high outputs.
// Values 10-15 decode to a dash (segment g only).
// Ports:
//   digit  in  4  BCD digit
//   seg    out 7  {g,f,e,d,c,b,a}, 1 = segment lit
module bcd_to_seg
  import bcd_seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pattern lookup for one digit.
  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan
// Multiplexed three-digit seven-segment display driver. A packed BCD value
// is captured into a shadow register on load and copied into the display
// register only at frame boundaries, so a frame never mixes old and new
// digits. Each digit slot begins with a guard interval with all anodes off
// to prevent ghosting. Digits above 9 are shown as a dash and flagged.
//
// Optional feature: define BCD_SEG_SCAN_LZB_EN for leading-zero blanking
// (hundreds blanked when 0, tens blanked when hundreds and tens are 0).
//
// Ports:
//   clk         in  1   clock, rising edge
//   rst_n       in  1   asynchronous active-low reset
//   load        in  1   capture bcd_in this cycle
//   bcd_in      in  12  packed BCD {hundreds, tens, ones}
//   seg         out 7   {g,f,e,d,c,b,a} for the active digit (registered)
//   an          out 3   anode enables, an[0] ones .. an[2] hundreds (registered)
//   frame_tick  out 1   one-cycle pulse after the display register updates
//   digit_err   out 1   high while any displayed digit is > 9 (registered)
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] bcd_in,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        frame_tick,
  output logic        digit_err
);

  localparam int             CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  GUARD_LIM = CW'(GUARD_CYC);
  localparam logic [6:0]     SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0]     AN_OFF    = (AN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  slot_t          state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [11:0]    shadow_r;
  logic [11:0]    disp_r;
  logic [6:0]     seg_r, seg_s;
  logic [2:0]     an_r, an_s;
  logic           frame_tick_r;
  logic           digit_err_r, digit_err_s;
  logic           boundary_s;
  logic [3:0]     digit_s;
  logic [6:0]     dec_seg_s;
  logic [2:0]     an_hot_s;
  logic           guard_s;
  logic           blank_s;

  assign seg        = seg_r;
  assign an         = an_r;
  assign frame_tick = frame_tick_r;
  assign digit_err  = digit_err_r;

  // Last cycle of the hundreds slot: display register is refreshed here.
  assign boundary_s = (state_r == DIG2) && (cnt_r == CNT_LAST);
  assign digit_s    = bcd_digit(disp_r, 2'(state_r));

  bcd_to_seg u_dec (
    .digit (digit_s),
    .seg   (dec_seg_s)
  );

  // Slot state register and prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= DIG0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Prescaler increment and slot advance on prescaler wrap.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_ONE;
    if (cnt_r == CNT_LAST) begin
      cnt_s = '0;
      case (state_r)
        DIG0:    state_s = DIG1;
        DIG1:    state_s = DIG2;
        DIG2:    state_s = DIG0;
        default: state_s = DIG0;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Shadow capture on load; display refresh at the frame boundary. A load
  // on the boundary cycle lands in the shadow after the copy has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= 12'h000;
      disp_r   <= 12'h000;
    end else begin
      if (load) begin
        shadow_r <= bcd_in;
      end
      if (boundary_s) begin
        disp_r <= shadow_r;
      end
    end
  end

  // Anode selection, guard/blanking and output polarity.
  always_comb begin
    an_hot_s = 3'b000;
    case (state_r)
      DIG0:    an_hot_s = 3'b001;
      DIG1:    an_hot_s = 3'b010;
      DIG2:    an_hot_s = 3'b100;
      default: an_hot_s = 3'b000;
    endcase

    guard_s = (cnt_r < GUARD_LIM);

`ifdef BCD_SEG_SCAN_LZB_EN
    // Only zeros are blanked, so an invalid digit is never hidden.
    if (state_r == DIG2) begin
      blank_s = (disp_r[11:8] == 4'd0);
    end else if (state_r == DIG1) begin
      blank_s = (disp_r[11:8] == 4'd0) && (disp_r[7:4] == 4'd0);
    end else begin
      blank_s = 1'b0;
    end
`else
    blank_s = 1'b0;
`endif

    if (guard_s || blank_s) begin
      seg_s = SEG_OFF;
      an_s  = AN_OFF;
    end else begin
      seg_s = (SEG_ACTIVE_LOW != 0) ? ~dec_seg_s : dec_seg_s;
      an_s  = (AN_ACTIVE_LOW != 0) ? ~an_hot_s : an_hot_s;
    end

    digit_err_s = (disp_r[11:8] > 4'd9) || (disp_r[7:4] > 4'd9) ||
                  (disp_r[3:0] > 4'd9);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r        <= SEG_OFF;
      an_r         <= AN_OFF;
      frame_tick_r <= 1'b0;
      digit_err_r  <= 1'b0;
    end else begin
      seg_r        <= seg_s;
      an_r         <= an_s;
      frame_tick_r <= boundary_s;
      digit_err_r  <= digit_err_s;
    end
  end

endmodule
